// File: rtl/serial_tx_framer.sv
// Parallel-to-serial framer: buffers one N-bit word and shifts it out one bit per clock
// on shift/serial_in, with a programmable idle gap between words.
module serial_tx_framer #(
    parameter int N         = 8,
    parameter int GAP       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         shift,
    output logic         serial_in,
    output logic         word_done,
    output logic         busy
);

    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [BW-1:0] BCNT_LAST   = BW'(N - 1);
    localparam logic [BW-1:0] BCNT_PENULT = BW'(N - 2);
    localparam logic [GW-1:0] GCNT_LAST   = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   hold, sreg, sreg_nxt;
    logic           hold_full, hold_pop, load;
    logic [BW-1:0]  bcnt, bcnt_nxt;
    logic [GW-1:0]  gcnt, gcnt_nxt;
    logic           shift_nxt, serial_nxt, word_done_nxt;

    // sreg keeps the bit currently on serial_in at its outgoing end
    function automatic logic first_bit(input logic [N-1:0] w);
        return MSB_FIRST ? w[N-1] : w[0];
    endfunction

    function automatic logic next_bit(input logic [N-1:0] w);
        return MSB_FIRST ? w[N-2] : w[1];
    endfunction

    function automatic logic [N-1:0] advance(input logic [N-1:0] w);
        return MSB_FIRST ? {w[N-2:0], 1'b0} : {1'b0, w[N-1:1]};
    endfunction

    assign din_ready = !hold_full;
    assign busy      = (state != ST_IDLE) || hold_full;

    // Accept and pop are mutually exclusive: a pop needs hold_full, an accept needs it clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (din_valid && !hold_full) begin
            hold      <= din;
            hold_full <= 1'b1;
        end else if (hold_pop) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            sreg      <= '0;
            bcnt      <= '0;
            gcnt      <= '0;
            shift     <= 1'b0;
            serial_in <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            sreg      <= sreg_nxt;
            bcnt      <= bcnt_nxt;
            gcnt      <= gcnt_nxt;
            shift     <= shift_nxt;
            serial_in <= serial_nxt;
            word_done <= word_done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sreg_nxt      = sreg;
        bcnt_nxt      = bcnt;
        gcnt_nxt      = gcnt;
        shift_nxt     = 1'b0;
        serial_nxt    = 1'b0;
        word_done_nxt = 1'b0;
        hold_pop      = 1'b0;
        load          = 1'b0;

        case (state)
            ST_IDLE: begin
                load = hold_full;
            end
            ST_SHIFT: begin
                if (bcnt == BCNT_LAST) begin
                    if (GAP > 0) begin
                        state_nxt = ST_GAP;
                        gcnt_nxt  = '0;
                    end else if (hold_full) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    sreg_nxt      = advance(sreg);
                    bcnt_nxt      = bcnt + BW'(1);
                    shift_nxt     = 1'b1;
                    serial_nxt    = next_bit(sreg);
                    word_done_nxt = (bcnt == BCNT_PENULT);
                end
            end
            ST_GAP: begin
                if (gcnt == GCNT_LAST) begin
                    if (hold_full) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    gcnt_nxt = gcnt + GW'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Starting a word looks the same from IDLE, from the end of a gap, or back-to-back
        if (load) begin
            state_nxt  = ST_SHIFT;
            sreg_nxt   = hold;
            bcnt_nxt   = '0;
            shift_nxt  = 1'b1;
            serial_nxt = first_bit(hold);
            hold_pop   = 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_tx_framer.sv
// Bench for serial_tx_framer: three instances (GAP=1 MSB-first, GAP=0 MSB-first, GAP=1 LSB-first)
// checked against a downstream shift-register model and a per-instance scoreboard.
module tb_serial_tx_framer;

    localparam bit [2:0] MSB_CFG = 3'b011;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] din [3];
    logic [2:0] din_valid;
    logic [2:0] din_ready, shift, serial_in, word_done, busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  sbq0[$], sbq1[$], sbq2[$];
    logic [7:0]  model_q [3];
    int          done_cnt [3];
    logic [2:0]  prev_xfer;
    logic [31:0] slog;
    logic [7:0]  bw [4];
    int          at_edges [4];
    int          done_before;

    typedef struct {
        int         sel;
        logic [7:0] word;
        logic [7:0] stream;
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    serial_tx_framer #(.N(8), .GAP(1), .MSB_FIRST(1'b1)) dut_gap1 (
        .clk(clk), .rst_n(rst_n), .din(din[0]), .din_valid(din_valid[0]),
        .din_ready(din_ready[0]), .shift(shift[0]), .serial_in(serial_in[0]),
        .word_done(word_done[0]), .busy(busy[0])
    );

    serial_tx_framer #(.N(8), .GAP(0), .MSB_FIRST(1'b1)) dut_gap0 (
        .clk(clk), .rst_n(rst_n), .din(din[1]), .din_valid(din_valid[1]),
        .din_ready(din_ready[1]), .shift(shift[1]), .serial_in(serial_in[1]),
        .word_done(word_done[1]), .busy(busy[1])
    );

    serial_tx_framer #(.N(8), .GAP(1), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .din(din[2]), .din_valid(din_valid[2]),
        .din_ready(din_ready[2]), .shift(shift[2]), .serial_in(serial_in[2]),
        .word_done(word_done[2]), .busy(busy[2])
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic void sbPush(input int s, input logic [7:0] w);
        case (s)
            0:       sbq0.push_back(w);
            1:       sbq1.push_back(w);
            default: sbq2.push_back(w);
        endcase
    endfunction

    function automatic bit sbPop(input int s, output logic [7:0] w);
        w = '0;
        sbPop = 1'b0;
        case (s)
            0:       if (sbq0.size() > 0) begin w = sbq0.pop_front(); sbPop = 1'b1; end
            1:       if (sbq1.size() > 0) begin w = sbq1.pop_front(); sbPop = 1'b1; end
            default: if (sbq2.size() > 0) begin w = sbq2.pop_front(); sbPop = 1'b1; end
        endcase
    endfunction

    function automatic int sbSize(input int s);
        case (s)
            0:       return sbq0.size();
            1:       return sbq1.size();
            default: return sbq2.size();
        endcase
    endfunction

    // Downstream register model plus scoreboard, sampled mid-cycle on the falling edge
    task automatic monitorLane(input int s);
        logic [7:0] exp_w;
        bit         have;
        if (shift[s])
            model_q[s] = MSB_CFG[s] ? {model_q[s][6:0], serial_in[s]} : {serial_in[s], model_q[s][7:1]};
        if (word_done[s]) begin
            done_cnt[s]++;
            have = sbPop(s, exp_w);
            checkOutput($sformatf("sb_pending_lane%0d", s), 32'(have), 32'd1);
            if (have)
                checkOutput($sformatf("sb_q_lane%0d", s), 32'(model_q[s]), 32'(exp_w));
        end
        if (prev_xfer[s])
            checkOutput($sformatf("ready_drop_lane%0d", s), 32'(din_ready[s]), 32'd0);
        prev_xfer[s] = din_valid[s] && din_ready[s];
        if (prev_xfer[s])
            sbPush(s, din[s]);
    endtask

    initial begin
        prev_xfer = '0;
        for (int s = 0; s < 3; s++) begin
            model_q[s]  = '0;
            done_cnt[s] = 0;
        end
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sbq0.delete();
                sbq1.delete();
                sbq2.delete();
                prev_xfer = '0;
                for (int s = 0; s < 3; s++) model_q[s] = '0;
            end else begin
                for (int s = 0; s < 3; s++) monitorLane(s);
            end
        end
    end

    // Present one word and hold valid until the edge that takes it
    task automatic applyStimulus(input int sel, input logic [7:0] word);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        din[sel]       = word;
        din_valid[sel] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (din_ready[sel]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        din_valid[sel] = 1'b0;
        checkOutput($sformatf("xfer_lane%0d", sel), 32'(ok), 32'd1);
    endtask

    task automatic sendAndCheck(input int sel, input logic [7:0] word, input logic [7:0] stream);
        logic [7:0] got;
        int first_idx, nshift, ndone, done_idx, bad_idle;
        string tag;
        tag = $sformatf("v%0d_%02h", sel, word);
        applyStimulus(sel, word);
        got = '0; first_idx = -1; nshift = 0; ndone = 0; done_idx = -1; bad_idle = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (shift[sel]) begin
                if (first_idx < 0) first_idx = k;
                nshift++;
                got = {got[6:0], serial_in[sel]};
            end else if (serial_in[sel]) begin
                bad_idle++;
            end
            if (word_done[sel]) begin
                ndone++;
                done_idx = k;
            end
        end
        checkOutput({tag, "_latency"},   32'(first_idx), 32'd1);
        checkOutput({tag, "_shift_len"}, 32'(nshift),    32'd8);
        checkOutput({tag, "_stream"},    32'(got),       32'(stream));
        checkOutput({tag, "_done_cnt"},  32'(ndone),     32'd1);
        checkOutput({tag, "_done_pos"},  32'(done_idx),  32'd8);
        checkOutput({tag, "_idle_zero"}, 32'(bad_idle),  32'd0);
        checkOutput({tag, "_busy_end"},  32'(busy[sel]), 32'd0);
    endtask

    // Hold valid high across several words, recording the edge count of each transfer
    task automatic sendBurst(input int sel, input int n);
        int cnt, i;
        bit xfer;
        cnt = 0; i = 0;
        @(posedge clk); #1;
        din[sel]       = bw[0];
        din_valid[sel] = 1'b1;
        for (int c = 0; c < 200 && i < n; c++) begin
            @(negedge clk);
            xfer = din_ready[sel];
            @(posedge clk); #1;
            cnt++;
            if (xfer) begin
                at_edges[i] = cnt;
                i++;
                if (i < n) din[sel] = bw[i];
            end
        end
        din_valid[sel] = 1'b0;
        checkOutput($sformatf("burst_count_lane%0d", sel), 32'(i), 32'(n));
    endtask

    task automatic captureShift(input int sel, input int n);
        @(posedge clk); #1;
        slog = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            slog[k] = shift[sel];
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{sel: 0, word: 8'hB4, stream: 8'hB4};
        vecs[1] = '{sel: 0, word: 8'h01, stream: 8'h01};
        vecs[2] = '{sel: 0, word: 8'h80, stream: 8'h80};
        vecs[3] = '{sel: 2, word: 8'h01, stream: 8'h80};
        vecs[4] = '{sel: 2, word: 8'hB4, stream: 8'h2D};
        vecs[5] = '{sel: 2, word: 8'h0F, stream: 8'hF0};
        vecs[6] = '{sel: 1, word: 8'hC6, stream: 8'hC6};

        din_valid = '0;
        for (int s = 0; s < 3; s++) din[s] = '0;

        #1 rst_n = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            checkOutput($sformatf("rst_shift_lane%0d", s),  32'(shift[s]),     32'd0);
            checkOutput($sformatf("rst_ready_lane%0d", s),  32'(din_ready[s]), 32'd1);
            checkOutput($sformatf("rst_busy_lane%0d", s),   32'(busy[s]),      32'd0);
        end
        checkOutput("rst_serial",    32'(serial_in[0]), 32'd0);
        checkOutput("rst_word_done", 32'(word_done[0]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            sendAndCheck(vecs[i].sel, vecs[i].word, vecs[i].stream);

        // Two words with valid held: one idle gap cycle, second transfer right after the first load
        bw[0] = 8'hA5; bw[1] = 8'h3C;
        fork
            sendBurst(0, 2);
            captureShift(0, 24);
        join
        checkOutput("b2b_shift_pattern", slog, 32'h0007_FBFC);
        checkOutput("b2b_second_xfer",   32'(at_edges[1] - at_edges[0]), 32'd2);
        waitCycles(4);

        // GAP=0: three words run as one unbroken 24-cycle shift burst
        bw[0] = 8'hFF; bw[1] = 8'h00; bw[2] = 8'h81;
        fork
            sendBurst(1, 3);
            captureShift(1, 30);
        join
        checkOutput("gap0_shift_pattern", slog, 32'h03FF_FFFC);
        waitCycles(4);

        // Four words under backpressure: order, count and word period
        done_before = done_cnt[0];
        bw[0] = 8'h12; bw[1] = 8'h34; bw[2] = 8'h56; bw[3] = 8'h78;
        sendBurst(0, 4);
        checkOutput("bp_first_gap", 32'(at_edges[1] - at_edges[0]), 32'd2);
        checkOutput("bp_period",    32'(at_edges[3] - at_edges[2]), 32'd9);
        waitCycles(45);
        checkOutput("bp_words_done", 32'(done_cnt[0] - done_before), 32'd4);
        checkOutput("bp_sb_empty",   32'(sbSize(0)), 32'd0);

        // Asynchronous reset in the middle of a word
        applyStimulus(0, 8'hC3);
        repeat (4) @(posedge clk);
        #2;
        checkOutput("midrst_pre_shift", 32'(shift[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_shift",     32'(shift[0]),     32'd0);
        checkOutput("midrst_serial",    32'(serial_in[0]), 32'd0);
        checkOutput("midrst_ready",     32'(din_ready[0]), 32'd1);
        checkOutput("midrst_busy",      32'(busy[0]),      32'd0);
        checkOutput("midrst_word_done", 32'(word_done[0]), 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        captureShift(0, 6);
        checkOutput("postrst_idle_shift", slog, 32'd0);
        checkOutput("postrst_idle_busy",  32'(busy[0]), 32'd0);
        sendAndCheck(0, 8'h5A, 8'h5A);

        waitCycles(4);
        for (int s = 0; s < 3; s++)
            checkOutput($sformatf("sb_drain_lane%0d", s), 32'(sbSize(s)), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_tx_framer.md
# serial_tx_framer

Parallel-to-serial framer that drives the `shift`/`serial_in` pair of the downstream serial-in shift register. It accepts N-bit words over a valid/ready handshake and holds one word in a buffer. It then emits each word one bit per clock with `shift` asserted, and inserts a programmable idle gap between words. After each word completes, the downstream register's `Q` holds exactly the word that was sent.

## Interface
- `N`, 8: word width in bits; legal range is N ≥ 2.
- `GAP`, 1: number of idle cycles between words, with `shift`=0; GAP=0 gives back-to-back words.
- `MSB_FIRST`, 1: 1 sends bit N-1 first, so downstream `Q` equals `din` when the downstream register shifts toward the MSB; 0 sends bit 0 first.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `din` in N: parallel word to send.
- `din_valid` in 1: `din` is valid this cycle.
- `din_ready` out 1: the holding buffer is empty; a transfer occurs on a rising edge where `din_valid` & `din_ready`.
- `shift` out 1: registered; the downstream register samples `serial_in` on the rising edge that ends a `shift`=1 cycle.
- `serial_in` out 1: registered; the current data bit, forced to 0 whenever `shift`=0.
- `word_done` out 1: registered; high only during the cycle that presents the last bit of a word.
- `busy` out 1: state ≠ IDLE or buffer full.

## Operation
- Storage:
  - holding buffer `hold[N-1:0]` with flag `hold_full`;
  - shift-out register `sreg[N-1:0]`;
  - bit counter `bcnt` of width clog2(N);
  - gap counter `gcnt` of width clog2(GAP+1).
- `din_ready` = !`hold_full`, derived combinationally from the flag only; it never depends on `din_valid`.
- On an accepted transfer, `hold` is loaded with `din` and `hold_full` is set to 1.
- FSM states IDLE, SHIFT, GAP:
  - IDLE: `shift`=0. If `hold_full`:
    - load `sreg` from `hold` and clear `hold_full`;
    - set `bcnt`=0;
    - drive `shift`=1 and `serial_in`=first bit;
    - go to SHIFT.
  - SHIFT: `shift`=1. Each edge advances `sreg` and increments `bcnt`. On the edge ending the cycle where `bcnt`=N-1:
    - if GAP>0: go to GAP with `gcnt`=0 and `shift`=0;
    - if GAP=0 and `hold_full`: reload from `hold` and stay in SHIFT, so `shift` stays 1;
    - otherwise: go to IDLE.
  - GAP: `shift`=0. `gcnt` increments each cycle. On the edge ending cycle `gcnt`=GAP-1, go to IDLE, or load directly into SHIFT if `hold_full`.
- Buffer refill:
  - A new word may be accepted in the same cycle the buffer is emptied only if `hold_full` was already 0 in that cycle.
  - The buffer is never overwritten while full.
- Bit order:
  - MSB_FIRST=1: bits N-1 down to 0.
  - MSB_FIRST=0: bits 0 up to N-1.
- Reset (`rst_n`=0, asynchronous, also mid-word):
  - state is IDLE;
  - `hold_full`, `sreg`, `bcnt` and `gcnt` are 0;
  - `shift`, `serial_in`, `word_done` and `busy` are 0;
  - `din_ready` is 1.
  - Any partial or buffered word is discarded. Nothing resumes after release.
- Reset release: the first transfer may occur on the first rising edge with `rst_n`=1.

## Timing
- Latency: transfer on edge E0 into an idle block → `shift`=1 with the first bit from E1 to E(N+1). The downstream `Q` holds the full word after E(N+1).
- `word_done`=1 in the cycle between E N and E(N+1).
- Word period: N+GAP cycles when the buffer is refilled in time; exactly N cycles for GAP=0.
- Sustained throughput needs `din_valid` asserted at least one edge before the current word's last-bit edge; otherwise an extra IDLE cycle is inserted.
- `din_ready` drops the cycle after a transfer and rises the cycle after the buffer moves into `sreg`.
- A `din_valid` arriving while `din_ready`=0 is held off. `din` must stay stable until the transfer.

## Test plan
- Single word, N=8, GAP=1, MSB_FIRST=1, `din`=8'hB4:
  - `shift`=1 for exactly 8 cycles;
  - `serial_in` = 1,0,1,1,0,1,0,0;
  - `word_done` high on the 8th cycle only;
  - downstream model `Q`=8'hB4.
- Two back-to-back words 8'hA5 then 8'h3C, `din_valid` held high:
  - exactly 1 cycle of `shift`=0 between the words;
  - the second transfer occurs the cycle after the first word loads;
  - `Q` sequence is A5 then 3C.
- GAP=0, three words 8'hFF, 8'h00, 8'h81: `shift` stays 1 for 24 consecutive cycles with no gap.
- Backpressure: `din_valid` held high for four words.
  - `din_ready` is never 1 while `hold_full`;
  - no word is lost or duplicated;
  - the order is preserved.
- Reset mid-word: assert `rst_n`=0 during bit 3 of 8'hC3.
  - `shift`=0, `serial_in`=0, `din_ready`=1 immediately, before the next edge;
  - after release, idle until a new word 8'h5A is sent correctly.
- MSB_FIRST=0, `din`=8'h01: `serial_in` = 1,0,0,0,0,0,0,0.
